weight_loader: RTL

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/weight_loader.sv
// weight_loader: accepts one kernel of 16-bit weights over an AXI-stream
// slave (two elements per word) and writes it into a downstream weight buffer
// of BUF_ELEMS elements. It throttles the stream on buffer occupancy and waits
// until the buffer has handed out every element before it reports done.
module weight_loader #(
    parameter int BUF_ELEMS = 14,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [4:0]        kernel_len,
    input  logic [WORD_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              fifo_en,
    output logic [WORD_W-1:0] data_out,
    output logic [4:0]        weight_dim,
    input  logic              elem_taken,
    output logic              busy,
    output logic              done,
    output logic              len_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A word carries two elements, so a new word fits only while at least two slots are free.
    localparam logic [4:0] OCC_LIMIT = 5'(BUF_ELEMS - 2);

    state_t            state_r;
    logic [5:0]        words_left_r;
    logic [4:0]        occ_r;
    logic [4:0]        consumed_r;
    logic [4:0]        weight_dim_r;
    logic [WORD_W-1:0] data_out_r;
    logic              fifo_en_r;
    logic              busy_r;
    logic              done_r;
    logic              len_err_r;

    logic              hs_s;
    logic              final_word_s;
    logic [5:0]        words_init_s;
    logic [4:0]        occ_nxt_s;
    logic [4:0]        consumed_nxt_s;

    assign s_tready     = (state_r == LOAD) && (words_left_r != 6'd0) && (occ_r <= OCC_LIMIT);
    assign hs_s         = s_tvalid & s_tready;
    assign final_word_s = (words_left_r == 6'd1);
    // ceil(kernel_len / 2): an odd kernel still costs a whole final word.
    assign words_init_s = ({1'b0, kernel_len} + 6'd1) >> 1;

    assign fifo_en    = fifo_en_r;
    assign data_out   = data_out_r;
    assign weight_dim = weight_dim_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign len_err    = len_err_r;

    // Next occupancy: +2 per accepted word, -1 per element read, never below zero.
    always_comb begin
        occ_nxt_s = occ_r;
        case ({hs_s, elem_taken})
            2'b10:   occ_nxt_s = occ_r + 5'd2;
            2'b11:   occ_nxt_s = occ_r + 5'd1;
            2'b01: begin
                if (occ_r == 5'd0) begin
                    occ_nxt_s = 5'd0;
                end else begin
                    occ_nxt_s = occ_r - 5'd1;
                end
            end
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Next consumed count, so the final read can end DRAIN in its own cycle.
    always_comb begin
        consumed_nxt_s = consumed_r;
        if (elem_taken) begin
            consumed_nxt_s = consumed_r + 5'd1;
        end else begin
            consumed_nxt_s = consumed_r;
        end
    end

    // Control FSM with its counters and all registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= IDLE;
            words_left_r <= 6'd0;
            occ_r        <= 5'd0;
            consumed_r   <= 5'd0;
            weight_dim_r <= 5'd0;
            data_out_r   <= '0;
            fifo_en_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            len_err_r    <= 1'b0;
        end else begin
            fifo_en_r <= hs_s;
            done_r    <= 1'b0;
            if (hs_s) begin
                data_out_r <= s_tdata;
            end
            case (state_r)
                IDLE: begin
                    occ_r <= occ_nxt_s;
                    if (start) begin
                        if (kernel_len != 5'd0) begin
                            weight_dim_r <= kernel_len;
                            words_left_r <= words_init_s;
                            occ_r        <= 5'd0;
                            consumed_r   <= 5'd0;
                            len_err_r    <= 1'b0;
                            busy_r       <= 1'b1;
                            state_r      <= LOAD;
                        end else begin
                            len_err_r <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    occ_r      <= occ_nxt_s;
                    consumed_r <= consumed_nxt_s;
                    if (hs_s) begin
                        words_left_r <= words_left_r - 6'd1;
                        // A misplaced tlast is flagged but the word is still taken.
                        if (s_tlast != final_word_s) begin
                            len_err_r <= 1'b1;
                        end
                        if (final_word_s) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    occ_r      <= occ_nxt_s;
                    consumed_r <= consumed_nxt_s;
                    if (consumed_nxt_s == weight_dim_r) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    occ_r      <= occ_nxt_s;
                    consumed_r <= consumed_nxt_s;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
